// File: rtl/osd_rst_sequencer.sv
// Ordered reset release for the debug system: the system reset is released first,
// and the CPU reset follows after a programmable delay. CPUs therefore never run against a held interconnect.
module osd_rst_sequencer #(
  parameter int SYS_HOLD_CYCLES  = 16,
  parameter int CPU_DELAY_CYCLES = 8,
  parameter int CNT_WIDTH        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sys_rst_req,
  input  logic cpu_rst_req,
  output logic sys_rst,
  output logic cpu_rst,
  output logic busy,
  output logic seq_done
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ASSERT    = 2'd1;
  localparam logic [1:0] ST_SYS_HOLD  = 2'd2;
  localparam logic [1:0] ST_CPU_DELAY = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0] SYS_LOAD =
    CNT_WIDTH'((SYS_HOLD_CYCLES > 0) ? SYS_HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] CPU_LOAD =
    CNT_WIDTH'((CPU_DELAY_CYCLES > 0) ? CPU_DELAY_CYCLES - 1 : 0);

  // With no system hold phase, reset starts directly in the CPU delay phase.
  localparam logic [1:0]           RST_STATE = (SYS_HOLD_CYCLES > 0) ? ST_SYS_HOLD : ST_CPU_DELAY;
  localparam logic [CNT_WIDTH-1:0] RST_CNT   = (SYS_HOLD_CYCLES > 0) ? SYS_LOAD : CPU_LOAD;
  localparam logic                 RST_SYS   = (SYS_HOLD_CYCLES > 0);

  if (SYS_HOLD_CYCLES < 0 || SYS_HOLD_CYCLES >= (1 << CNT_WIDTH)) begin : g_bad_sys_hold
    $error("SYS_HOLD_CYCLES must be in [0, 2**CNT_WIDTH)");
  end
  if (CPU_DELAY_CYCLES < 0 || CPU_DELAY_CYCLES >= (1 << CNT_WIDTH)) begin : g_bad_cpu_delay
    $error("CPU_DELAY_CYCLES must be in [0, 2**CNT_WIDTH)");
  end

  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_sys_rst;
  logic                 r_cpu_rst;
  logic                 r_busy;
  logic                 r_seq_done;

  logic [1:0]           w_state_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_sys_rst_nxt;
  logic                 w_cpu_rst_nxt;
  logic                 w_busy_nxt;
  logic                 w_seq_done_nxt;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latch).
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (sys_rst_req) w_state_nxt = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (!sys_rst_req) begin
          if (SYS_HOLD_CYCLES > 0) begin
            w_state_nxt = ST_SYS_HOLD;
            w_cnt_nxt   = SYS_LOAD;
          end else if (CPU_DELAY_CYCLES > 0) begin
            w_state_nxt = ST_CPU_DELAY;
            w_cnt_nxt   = CPU_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_SYS_HOLD: begin
        if (sys_rst_req) begin
          w_state_nxt = ST_ASSERT;
        end else if (r_cnt == '0) begin
          if (CPU_DELAY_CYCLES > 0) begin
            w_state_nxt = ST_CPU_DELAY;
            w_cnt_nxt   = CPU_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_CPU_DELAY: begin
        if (sys_rst_req) begin
          w_state_nxt = ST_ASSERT;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Outputs are registered from the next state; cpu_rst_req only matters while staying in IDLE.
    w_sys_rst_nxt  = (w_state_nxt == ST_ASSERT) || (w_state_nxt == ST_SYS_HOLD);
    w_cpu_rst_nxt  = (w_state_nxt != ST_IDLE) || ((r_state == ST_IDLE) && cpu_rst_req);
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
    w_seq_done_nxt = (w_state_nxt == ST_IDLE) && (r_state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
    if (rst) begin
      r_state    <= RST_STATE;
      r_cnt      <= RST_CNT;
      r_sys_rst  <= RST_SYS;
      r_cpu_rst  <= 1'b1;
      r_busy     <= 1'b1;
      r_seq_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sys_rst  <= w_sys_rst_nxt;
      r_cpu_rst  <= w_cpu_rst_nxt;
      r_busy     <= w_busy_nxt;
      r_seq_done <= w_seq_done_nxt;
    end
  end

  assign sys_rst  = r_sys_rst | rst;
  assign cpu_rst  = r_cpu_rst | rst;
  assign busy     = r_busy;
  assign seq_done = r_seq_done;

endmodule

// File: tb/tb_osd_rst_sequencer.sv
// Bench for osd_rst_sequencer: default and zero-length instances, directed sequences,
// a vector table and random traffic against a release-age reference model.
module tb_osd_rst_sequencer;

  localparam int SYS_H = 16;
  localparam int CPU_D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sys_rst_req = 1'b0;
  logic cpu_rst_req = 1'b0;
  logic sys_rst, cpu_rst, busy, seq_done;
  logic z_sys_rst, z_cpu_rst, z_busy, z_seq_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  osd_rst_sequencer #(
    .SYS_HOLD_CYCLES (SYS_H),
    .CPU_DELAY_CYCLES(CPU_D),
    .CNT_WIDTH       (8)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .sys_rst_req(sys_rst_req),
    .cpu_rst_req(cpu_rst_req),
    .sys_rst    (sys_rst),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .seq_done   (seq_done)
  );

  osd_rst_sequencer #(
    .SYS_HOLD_CYCLES (0),
    .CPU_DELAY_CYCLES(0),
    .CNT_WIDTH       (8)
  ) u_zero (
    .clk        (clk),
    .rst        (rst),
    .sys_rst_req(sys_rst_req),
    .cpu_rst_req(cpu_rst_req),
    .sys_rst    (z_sys_rst),
    .cpu_rst    (z_cpu_rst),
    .busy       (z_busy),
    .seq_done   (z_seq_done)
  );

  typedef struct {
    logic       r;
    logic       s;
    logic       c;
    logic [3:0] exp;  // {sys_rst, cpu_rst, busy, seq_done}
  } vec_t;

  vec_t vecs [8];

  // Reference model: tracks how many cycles have elapsed since the release point.
  bit m_assert = 1'b0;
  bit m_seq    = 1'b0;
  int m_age    = 0;
  bit m_cpu    = 1'b0;
  bit m_done   = 1'b0;

  function automatic logic [3:0] dut_out();
    return {sys_rst, cpu_rst, busy, seq_done};
  endfunction

  function automatic logic [3:0] zero_out();
    return {z_sys_rst, z_cpu_rst, z_busy, z_seq_done};
  endfunction

  function automatic logic [3:0] rel_exp(input int k);
    return {k < SYS_H, k < SYS_H + CPU_D, k < SYS_H + CPU_D, k == SYS_H + CPU_D};
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {sys,cpu,busy,done}=%b, expected %b", name, got, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic c);
    rst         = r;
    sys_rst_req = s;
    cpu_rst_req = c;
    @(posedge clk);
    #2;
  endtask

  task automatic model_step(input logic r, input logic s, input logic c);
    m_done = 1'b0;
    if (r) begin
      m_assert = 1'b0;
      m_seq    = 1'b1;
      m_age    = 0;
    end else if (s) begin
      m_assert = 1'b1;
      m_seq    = 1'b0;
    end else if (m_assert) begin
      m_assert = 1'b0;
      m_seq    = 1'b1;
      m_age    = 0;
    end else if (m_seq) begin
      m_age++;
      if (m_age == SYS_H + CPU_D) begin
        m_seq  = 1'b0;
        m_done = 1'b1;
        m_cpu  = 1'b0;
      end
    end else begin
      m_cpu = c;
    end
  endtask

  function automatic logic [3:0] model_exp(input logic r);
    logic [3:0] e;
    if (m_assert)   e = 4'b1110;
    else if (m_seq) e = {m_age < SYS_H, 1'b1, 1'b1, 1'b0};
    else            e = {1'b0, m_cpu, 1'b0, m_done};
    e[3] = e[3] | r;
    e[2] = e[2] | r;
    return e;
  endfunction

  // Checks a full release: k=0 is the first cycle after the release point.
  task automatic release_check(input string name, input bit from_rst);
    if (from_rst) begin
      rst         = 1'b0;
      sys_rst_req = 1'b0;
      cpu_rst_req = 1'b0;
      #1;
    end else begin
      cycle(1'b0, 1'b0, 1'b0);
    end
    check($sformatf("%s_k0", name), dut_out(), rel_exp(0));
    for (int k = 1; k < 28; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      check($sformatf("%s_k%0d", name, k), dut_out(), rel_exp(k));
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 64) begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b after %0d cycles, expected 0", name, busy, n);
    end
  endtask

  initial begin
    // Power-on: reset state, then the default 16+8 release.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      check($sformatf("rst_state%0d", i), dut_out(), 4'b1110);
      check($sformatf("zero_rst_state%0d", i), zero_out(), 4'b1110);
    end
    release_check("por", 1'b1);

    // CPU-only reset, request priority and reset from SYS_HOLD.
    vecs[0] = '{1'b0, 1'b0, 1'b1, 4'b0100};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 4'b0100};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 4'b0100};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 4'b0100};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 4'b1110};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 4'b1110};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 4'b1110};
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].r, vecs[i].s, vecs[i].c);
      check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end
    wait_idle("vec_idle");

    // Software system reset held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      check($sformatf("sw_assert%0d", i), dut_out(), 4'b1110);
    end
    release_check("sw", 1'b0);

    // Abort on the 3rd CPU_DELAY cycle, then a full release.
    cycle(1'b0, 1'b1, 1'b0);
    check("abort_assert", dut_out(), 4'b1110);
    for (int k = 0; k <= SYS_H + 2; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      check($sformatf("abort_pre_k%0d", k), dut_out(), rel_exp(k));
    end
    cycle(1'b0, 1'b1, 1'b0);
    check("abort_reassert", dut_out(), 4'b1110);
    release_check("abort_rel", 1'b0);

    // rst during SYS_HOLD with the counter at 5.
    cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k <= 10; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      check($sformatf("midrst_pre_k%0d", k), dut_out(), rel_exp(k));
    end
    rst = 1'b1;
    #1;
    check("midrst_comb", dut_out(), 4'b1110);
    cycle(1'b1, 1'b0, 1'b0);
    check("midrst_edge", dut_out(), 4'b1110);
    release_check("midrst", 1'b1);

    // Zero-length phases: one-cycle request.
    cycle(1'b0, 1'b1, 1'b0);
    check("zero_assert", zero_out(), 4'b1110);
    cycle(1'b0, 1'b0, 1'b0);
    check("zero_done", zero_out(), 4'b0001);
    cycle(1'b0, 1'b0, 1'b0);
    check("zero_idle", zero_out(), 4'b0000);
    wait_idle("pre_rand_idle");

    // Random traffic against the reference model.
    begin
      logic r, s, c;
      int s_hold;
      s_hold = 0;
      cycle(1'b1, 1'b0, 1'b0);
      model_step(1'b1, 1'b0, 1'b0);
      check("rand_sync", dut_out(), model_exp(1'b1));
      for (int i = 0; i < 2000; i++) begin
        r = ($urandom_range(0, 149) == 0);
        if (s_hold > 0) begin
          s = 1'b1;
          s_hold--;
        end else if ($urandom_range(0, 29) == 0) begin
          s = 1'b1;
          s_hold = $urandom_range(0, 5);
        end else begin
          s = 1'b0;
        end
        c = ($urandom_range(0, 3) == 0);
        cycle(r, s, c);
        model_step(r, s, c);
        check($sformatf("rand%0d", i), dut_out(), model_exp(r));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
